mem_bus_arbiter: RTL and testbench

Two-requester AXI4-Lite arbiter that shares the single external memory port between the core's MEMORY_INTERFACE (requester 0) and a second bus master (requester 1: debug loader or DMA). Read and write channels are arbitrated independently, each with its own round-robin pointer and ownership FSM. Ownership is held from address grant until the response handshake completes. The block sits between the mriscvcore AXI4-Lite master pins and the system memory slave.

---
 rtl/mem_bus_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master AXI4-Lite arbiter onto one memory slave port. The read and write channels each have their
// own round-robin pointer and ownership FSM. Payload and handshake paths are combinational muxes on the registered owner.
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_ARdata,  m1_ARdata,
  input  logic [31:0] m0_AWdata,  m1_AWdata,
  input  logic [31:0] m0_Wdata,   m1_Wdata,
  input  logic [2:0]  m0_ARprot,  m1_ARprot,
  input  logic [2:0]  m0_AWprot,  m1_AWprot,
  input  logic [3:0]  m0_Wstrb,   m1_Wstrb,
  input  logic        m0_ARvalid, m1_ARvalid,
  input  logic        m0_AWvalid, m1_AWvalid,
  input  logic        m0_Wvalid,  m1_Wvalid,
  input  logic        m0_RReady,  m1_RReady,
  input  logic        m0_Bready,  m1_Bready,
  output logic        m0_ARready, m1_ARready,
  output logic        m0_AWready, m1_AWready,
  output logic        m0_Wready,  m1_Wready,
  output logic        m0_Rvalid,  m1_Rvalid,
  output logic        m0_Bvalid,  m1_Bvalid,
  output logic [31:0] m0_Rdata,   m1_Rdata,
  output logic [31:0] s_ARdata,
  output logic [31:0] s_AWdata,
  output logic [31:0] s_Wdata,
  output logic [2:0]  s_ARprot,
  output logic [2:0]  s_AWprot,
  output logic [3:0]  s_Wstrb,
  output logic        s_ARvalid,
  output logic        s_AWvalid,
  output logic        s_Wvalid,
  output logic        s_RReady,
  output logic        s_Bready,
  input  logic        s_ARready,
  input  logic        s_AWready,
  input  logic        s_Wready,
  input  logic        s_Rvalid,
  input  logic        s_Bvalid,
  input  logic [31:0] s_Rdata,
  output logic [1:0]  rd_gnt,
  output logic [1:0]  wr_gnt
);
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_state_t;

  logic [1:0][31:0] ar_data, aw_data, w_data, r_data;
  logic [1:0][2:0]  ar_prot, aw_prot;
  logic [1:0][3:0]  w_strb;
  logic [1:0]       ar_valid, aw_valid, w_valid, r_ready, b_ready;
  logic [1:0]       ar_ready, aw_ready, w_ready, r_valid, b_valid;

  assign ar_data  = {m1_ARdata,  m0_ARdata};
  assign aw_data  = {m1_AWdata,  m0_AWdata};
  assign w_data   = {m1_Wdata,   m0_Wdata};
  assign ar_prot  = {m1_ARprot,  m0_ARprot};
  assign aw_prot  = {m1_AWprot,  m0_AWprot};
  assign w_strb   = {m1_Wstrb,   m0_Wstrb};
  assign ar_valid = {m1_ARvalid, m0_ARvalid};
  assign aw_valid = {m1_AWvalid, m0_AWvalid};
  assign w_valid  = {m1_Wvalid,  m0_Wvalid};
  assign r_ready  = {m1_RReady,  m0_RReady};
  assign b_ready  = {m1_Bready,  m0_Bready};

  assign {m1_ARready, m0_ARready} = ar_ready;
  assign {m1_AWready, m0_AWready} = aw_ready;
  assign {m1_Wready,  m0_Wready}  = w_ready;
  assign {m1_Rvalid,  m0_Rvalid}  = r_valid;
  assign {m1_Bvalid,  m0_Bvalid}  = b_valid;
  assign m0_Rdata = r_data[0];
  assign m1_Rdata = r_data[1];

  // ---------------- read channel ----------------
  rd_state_t rd_state, rd_state_nxt;
  logic      rd_own, rd_own_nxt, rd_ptr, rd_ptr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= R_IDLE;
      rd_own   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      rd_state <= rd_state_nxt;
      rd_own   <= rd_own_nxt;
      rd_ptr   <= rd_ptr_nxt;
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    rd_own_nxt   = rd_own;
    rd_ptr_nxt   = rd_ptr;
    s_ARdata     = '0;
    s_ARprot     = '0;
    s_ARvalid    = 1'b0;
    s_RReady     = 1'b0;
    ar_ready     = '0;
    r_valid      = '0;
    r_data       = '0;
    rd_gnt       = '0;
    unique case (rd_state)
      R_IDLE: if (|ar_valid) begin
        // the pointer breaks ties only when both masters request
        rd_own_nxt   = (&ar_valid) ? rd_ptr : ar_valid[1];
        rd_state_nxt = R_ADDR;
      end
      R_ADDR: begin
        rd_gnt[rd_own]   = 1'b1;
        s_ARdata         = ar_data[rd_own];
        s_ARprot         = ar_prot[rd_own];
        s_ARvalid        = ar_valid[rd_own];
        ar_ready[rd_own] = s_ARready;
        if (ar_valid[rd_own] && s_ARready) rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        rd_gnt[rd_own]  = 1'b1;
        r_valid[rd_own] = s_Rvalid;
        r_data[rd_own]  = s_Rdata;
        s_RReady        = r_ready[rd_own];
        if (s_Rvalid && r_ready[rd_own]) begin
          rd_state_nxt = R_IDLE;
          rd_ptr_nxt   = ~rd_own;
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // ---------------- write channel ----------------
  wr_state_t wr_state, wr_state_nxt;
  logic      wr_own, wr_own_nxt, wr_ptr, wr_ptr_nxt;
  logic      aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic      aw_hs, w_hs;
  logic [1:0] wr_req;

  assign wr_req = aw_valid | w_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= W_IDLE;
      wr_own   <= 1'b0;
      wr_ptr   <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      wr_own   <= wr_own_nxt;
      wr_ptr   <= wr_ptr_nxt;
      aw_done  <= aw_done_nxt;
      w_done   <= w_done_nxt;
    end
  end

  always_comb begin
    wr_state_nxt = wr_state;
    wr_own_nxt   = wr_own;
    wr_ptr_nxt   = wr_ptr;
    aw_done_nxt  = aw_done;
    w_done_nxt   = w_done;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;
    s_AWdata     = '0;
    s_AWprot     = '0;
    s_Wdata      = '0;
    s_Wstrb      = '0;
    s_AWvalid    = 1'b0;
    s_Wvalid     = 1'b0;
    s_Bready     = 1'b0;
    aw_ready     = '0;
    w_ready      = '0;
    b_valid      = '0;
    wr_gnt       = '0;
    unique case (wr_state)
      W_IDLE: if (|wr_req) begin
        wr_own_nxt   = (&wr_req) ? wr_ptr : wr_req[1];
        wr_state_nxt = W_XFER;
      end
      W_XFER: begin
        wr_gnt[wr_own]   = 1'b1;
        s_AWdata         = aw_data[wr_own];
        s_AWprot         = aw_prot[wr_own];
        s_Wdata          = w_data[wr_own];
        s_Wstrb          = w_strb[wr_own];
        // a channel that already handshook is masked so it cannot issue twice
        s_AWvalid        = aw_valid[wr_own] & ~aw_done;
        s_Wvalid         = w_valid[wr_own] & ~w_done;
        aw_ready[wr_own] = s_AWready & ~aw_done;
        w_ready[wr_own]  = s_Wready & ~w_done;
        aw_hs            = aw_valid[wr_own] & ~aw_done & s_AWready;
        w_hs             = w_valid[wr_own] & ~w_done & s_Wready;
        if (aw_hs) aw_done_nxt = 1'b1;
        if (w_hs)  w_done_nxt  = 1'b1;
        if ((aw_done | aw_hs) && (w_done | w_hs)) wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        wr_gnt[wr_own]  = 1'b1;
        b_valid[wr_own] = s_Bvalid;
        s_Bready        = b_ready[wr_own];
        if (s_Bvalid && b_ready[wr_own]) begin
          wr_state_nxt = W_IDLE;
          wr_ptr_nxt   = ~wr_own;
          aw_done_nxt  = 1'b0;
          w_done_nxt   = 1'b0;
        end
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: the bench plays both masters and the slave, and each value it
// expects is computed by hand from the stimulus it drives.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_ARdata, m1_ARdata, m0_AWdata, m1_AWdata, m0_Wdata, m1_Wdata;
  logic [2:0]  m0_ARprot, m1_ARprot, m0_AWprot, m1_AWprot;
  logic [3:0]  m0_Wstrb, m1_Wstrb;
  logic        m0_ARvalid, m1_ARvalid, m0_AWvalid, m1_AWvalid, m0_Wvalid, m1_Wvalid;
  logic        m0_RReady, m1_RReady, m0_Bready, m1_Bready;
  logic        m0_ARready, m1_ARready, m0_AWready, m1_AWready, m0_Wready, m1_Wready;
  logic        m0_Rvalid, m1_Rvalid, m0_Bvalid, m1_Bvalid;
  logic [31:0] m0_Rdata, m1_Rdata;
  logic [31:0] s_ARdata, s_AWdata, s_Wdata;
  logic [2:0]  s_ARprot, s_AWprot;
  logic [3:0]  s_Wstrb;
  logic        s_ARvalid, s_AWvalid, s_Wvalid, s_RReady, s_Bready;
  logic        s_ARready, s_AWready, s_Wready, s_Rvalid, s_Bvalid;
  logic [31:0] s_Rdata;
  logic [1:0]  rd_gnt, wr_gnt;

  int errs = 0, checks = 0;
  logic [31:0] a0, a1;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_ARdata(m0_ARdata), .m1_ARdata(m1_ARdata), .m0_AWdata(m0_AWdata), .m1_AWdata(m1_AWdata),
    .m0_Wdata(m0_Wdata), .m1_Wdata(m1_Wdata),
    .m0_ARprot(m0_ARprot), .m1_ARprot(m1_ARprot), .m0_AWprot(m0_AWprot), .m1_AWprot(m1_AWprot),
    .m0_Wstrb(m0_Wstrb), .m1_Wstrb(m1_Wstrb),
    .m0_ARvalid(m0_ARvalid), .m1_ARvalid(m1_ARvalid), .m0_AWvalid(m0_AWvalid), .m1_AWvalid(m1_AWvalid),
    .m0_Wvalid(m0_Wvalid), .m1_Wvalid(m1_Wvalid),
    .m0_RReady(m0_RReady), .m1_RReady(m1_RReady), .m0_Bready(m0_Bready), .m1_Bready(m1_Bready),
    .m0_ARready(m0_ARready), .m1_ARready(m1_ARready), .m0_AWready(m0_AWready), .m1_AWready(m1_AWready),
    .m0_Wready(m0_Wready), .m1_Wready(m1_Wready),
    .m0_Rvalid(m0_Rvalid), .m1_Rvalid(m1_Rvalid), .m0_Bvalid(m0_Bvalid), .m1_Bvalid(m1_Bvalid),
    .m0_Rdata(m0_Rdata), .m1_Rdata(m1_Rdata),
    .s_ARdata(s_ARdata), .s_AWdata(s_AWdata), .s_Wdata(s_Wdata),
    .s_ARprot(s_ARprot), .s_AWprot(s_AWprot), .s_Wstrb(s_Wstrb),
    .s_ARvalid(s_ARvalid), .s_AWvalid(s_AWvalid), .s_Wvalid(s_Wvalid),
    .s_RReady(s_RReady), .s_Bready(s_Bready),
    .s_ARready(s_ARready), .s_AWready(s_AWready), .s_Wready(s_Wready),
    .s_Rvalid(s_Rvalid), .s_Bvalid(s_Bvalid), .s_Rdata(s_Rdata),
    .rd_gnt(rd_gnt), .wr_gnt(wr_gnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One arbitrated read while both masters keep ARvalid high; slave returns data = address.
  task automatic rd_one(input int o);
    logic [31:0] a;
    a = (o == 0) ? a0 : a1;
    tick(); s_ARready = 1'b1; #1;
    chk("cont_gnt", {30'd0, rd_gnt}, (o == 0) ? 32'd1 : 32'd2);
    chk("cont_araddr", s_ARdata, a);
    tick(); s_ARready = 1'b0; s_Rvalid = 1'b1; s_Rdata = a; #1;
    chk("cont_rvalid", {31'd0, (o == 0) ? m0_Rvalid : m1_Rvalid}, 32'd1);
    chk("cont_rdata", (o == 0) ? m0_Rdata : m1_Rdata, a);
    chk("cont_other_rvalid", {31'd0, (o == 0) ? m1_Rvalid : m0_Rvalid}, 32'd0);
    tick(); s_Rvalid = 1'b0; s_Rdata = '0;
    if (o == 0) begin a0 = a0 + 32'd4; m0_ARdata = a0; end
    else        begin a1 = a1 + 32'd4; m1_ARdata = a1; end
    #1;
    chk("cont_bubble", {30'd0, rd_gnt}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    {m0_ARdata, m1_ARdata, m0_AWdata, m1_AWdata, m0_Wdata, m1_Wdata} = '0;
    {m0_ARprot, m1_ARprot, m0_AWprot, m1_AWprot, m0_Wstrb, m1_Wstrb} = '0;
    {m0_ARvalid, m1_ARvalid, m0_AWvalid, m1_AWvalid, m0_Wvalid, m1_Wvalid} = '0;
    {m0_RReady, m1_RReady, m0_Bready, m1_Bready} = '0;
    {s_ARready, s_AWready, s_Wready, s_Rvalid, s_Bvalid} = '0;
    s_Rdata = '0;
    // requests held during reset must not be granted or leak onto the slave
    m0_ARvalid = 1'b1; m0_ARdata = 32'h100; m1_AWvalid = 1'b1; m1_AWdata = 32'h200; m1_Wdata = 32'h55;
    tick(); tick(); #1;
    chk("rst_gnt", {28'd0, rd_gnt, wr_gnt}, 32'd0);
    chk("rst_svalid", {27'd0, s_ARvalid, s_AWvalid, s_Wvalid, s_RReady, s_Bready}, 32'd0);
    chk("rst_mready", {22'd0, m0_ARready, m1_ARready, m0_AWready, m1_AWready, m0_Wready, m1_Wready,
                       m0_Rvalid, m1_Rvalid, m0_Bvalid, m1_Bvalid}, 32'd0);
    chk("rst_sdata", s_ARdata | s_AWdata | s_Wdata, 32'd0);
    m0_ARvalid = 1'b0; m1_AWvalid = 1'b0; m1_AWdata = '0; m1_Wdata = '0;
    rst = 1'b0;
    tick();

    // single read from m0, slave answers 3 cycles after AR
    m0_ARdata = 32'h100; m0_ARvalid = 1'b1; #1;
    chk("rd_idle_gnt", {30'd0, rd_gnt}, 32'd0);
    tick(); s_ARready = 1'b1; #1;
    chk("rd_gnt", {30'd0, rd_gnt}, 32'd1);
    chk("rd_s_arvalid", {31'd0, s_ARvalid}, 32'd1);
    chk("rd_s_araddr", s_ARdata, 32'h100);
    chk("rd_m0_arready", {31'd0, m0_ARready}, 32'd1);
    chk("rd_m1_quiet", {27'd0, m1_ARready, m1_Rvalid, m1_AWready, m1_Wready, m1_Bvalid}, 32'd0);
    tick(); m0_ARvalid = 1'b0; s_ARready = 1'b0; m0_RReady = 1'b1; #1;
    chk("rd_wait_arvalid", {31'd0, s_ARvalid}, 32'd0);
    chk("rd_wait_rvalid", {31'd0, m0_Rvalid}, 32'd0);
    tick(); tick(); s_Rvalid = 1'b1; s_Rdata = 32'hDEADBEEF; #1;
    chk("rd_m0_rvalid", {31'd0, m0_Rvalid}, 32'd1);
    chk("rd_m0_rdata", m0_Rdata, 32'hDEADBEEF);
    chk("rd_m1_rdata", m1_Rdata, 32'd0);
    chk("rd_s_rready", {31'd0, s_RReady}, 32'd1);
    tick(); s_Rvalid = 1'b0; s_Rdata = '0; m0_RReady = 1'b0; #1;
    chk("rd_done_gnt", {30'd0, rd_gnt}, 32'd0);

    // reset while m1 owns the read channel in the data phase
    m1_ARdata = 32'h500; m1_ARvalid = 1'b1; m1_RReady = 1'b1; s_ARready = 1'b1;
    tick();
    tick(); m1_ARvalid = 1'b0; s_ARready = 1'b0; #1;
    chk("rstmid_pre_gnt", {30'd0, rd_gnt}, 32'd2);
    rst = 1'b1;
    tick(); #1;
    chk("rstmid_gnt", {28'd0, rd_gnt, wr_gnt}, 32'd0);
    chk("rstmid_s", {27'd0, s_ARvalid, s_AWvalid, s_Wvalid, s_RReady, s_Bready}, 32'd0);
    rst = 1'b0;
    tick(); s_Rvalid = 1'b1; s_Rdata = 32'h77; #1;
    chk("rstmid_late_rvalid", {30'd0, m0_Rvalid, m1_Rvalid}, 32'd0);
    chk("rstmid_late_rdata", m0_Rdata | m1_Rdata, 32'd0);
    chk("rstmid_late_rready", {31'd0, s_RReady}, 32'd0);
    tick(); s_Rvalid = 1'b0; s_Rdata = '0; m1_RReady = 1'b0;

    // contention: pointer is back at 0 after reset, so m0 goes first and grants alternate
    a0 = 32'h1000; a1 = 32'h2000;
    m0_ARdata = a0; m1_ARdata = a1;
    m0_ARvalid = 1'b1; m1_ARvalid = 1'b1; m0_RReady = 1'b1; m1_RReady = 1'b1;
    for (int i = 0; i < 8; i++) rd_one(i % 2);
    m0_ARvalid = 1'b0; m1_ARvalid = 1'b0; m0_RReady = 1'b0; m1_RReady = 1'b0;
    tick();

    // m1 write, AW first, W two cycles later
    m1_AWdata = 32'h200; m1_AWvalid = 1'b1; m1_Bready = 1'b1; s_AWready = 1'b1; s_Wready = 1'b1;
    tick(); #1;
    chk("wr_gnt", {30'd0, wr_gnt}, 32'd2);
    chk("wr_s_awvalid", {31'd0, s_AWvalid}, 32'd1);
    chk("wr_s_awaddr", s_AWdata, 32'h200);
    chk("wr_m1_awready", {31'd0, m1_AWready}, 32'd1);
    chk("wr_m0_awready", {31'd0, m0_AWready}, 32'd0);
    chk("wr_s_wvalid_early", {31'd0, s_Wvalid}, 32'd0);
    tick(); #1;
    chk("wr_aw_masked", {30'd0, s_AWvalid, m1_AWready}, 32'd0);
    chk("wr_hold_gnt", {30'd0, wr_gnt}, 32'd2);
    m1_AWvalid = 1'b0;
    tick(); m1_Wdata = 32'h12345678; m1_Wstrb = 4'hF; m1_Wvalid = 1'b1; #1;
    chk("wr_s_wvalid", {31'd0, s_Wvalid}, 32'd1);
    chk("wr_s_wdata", s_Wdata, 32'h12345678);
    chk("wr_s_wstrb", {28'd0, s_Wstrb}, 32'hF);
    chk("wr_m1_wready", {31'd0, m1_Wready}, 32'd1);
    tick(); m1_Wvalid = 1'b0; #1;
    chk("wr_resp_wvalid", {31'd0, s_Wvalid}, 32'd0);
    chk("wr_resp_bready", {31'd0, s_Bready}, 32'd1);
    s_Bvalid = 1'b1; #1;
    chk("wr_m1_bvalid", {31'd0, m1_Bvalid}, 32'd1);
    chk("wr_m0_bvalid", {31'd0, m0_Bvalid}, 32'd0);
    tick(); s_Bvalid = 1'b0; m1_Bready = 1'b0; #1;
    chk("wr_done_gnt", {30'd0, wr_gnt}, 32'd0);

    // concurrent: m0 read and m1 write in flight together
    m0_ARdata = 32'h300; m0_ARvalid = 1'b1; m0_RReady = 1'b1; s_ARready = 1'b1;
    m1_AWdata = 32'h400; m1_AWvalid = 1'b1; m1_Wdata = 32'hCAFEF00D; m1_Wstrb = 4'h3; m1_Wvalid = 1'b1;
    m1_Bready = 1'b1;
    tick(); #1;
    chk("cc_gnts", {28'd0, rd_gnt, wr_gnt}, 32'b0110);
    chk("cc_s_araddr", s_ARdata, 32'h300);
    chk("cc_s_awaddr", s_AWdata, 32'h400);
    chk("cc_s_wdata", s_Wdata, 32'hCAFEF00D);
    chk("cc_s_wstrb", {28'd0, s_Wstrb}, 32'h3);
    tick(); m0_ARvalid = 1'b0; m1_AWvalid = 1'b0; m1_Wvalid = 1'b0; s_ARready = 1'b0;
    s_Rvalid = 1'b1; s_Rdata = 32'h55AA55AA; s_Bvalid = 1'b1; #1;
    chk("cc_m0_r", {31'd0, m0_Rvalid}, 32'd1);
    chk("cc_m0_rdata", m0_Rdata, 32'h55AA55AA);
    chk("cc_m1_b", {31'd0, m1_Bvalid}, 32'd1);
    chk("cc_cross", {30'd0, m1_Rvalid, m0_Bvalid}, 32'd0);
    tick(); s_Rvalid = 1'b0; s_Bvalid = 1'b0; m0_RReady = 1'b0; m1_Bready = 1'b0; #1;
    chk("cc_done_gnts", {28'd0, rd_gnt, wr_gnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
